// File: rtl/coin_credit_if.sv
// Bundle of the coin/keypad/vend-stage signals seen by the credit collector.
// slave: the collector's view; master: the environment that drives it.
interface coin_credit_if #(
  parameter int unsigned CREDIT_W = 4
);
  logic                coin_valid;
  logic [1:0]          coin_value;
  logic                sel_valid;
  logic [2:0]          sel_code;
  logic                cancel;
  logic                rsp_valid;
  logic                rsp_dispense;
  logic [CREDIT_W-1:0] rsp_change;
  logic                rsp_out_of_stock;
  logic [CREDIT_W-1:0] money_in;
  logic [2:0]          product_code;
  logic                txn_valid;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund;
  logic                busy;

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_code, cancel,
           rsp_valid, rsp_dispense, rsp_change, rsp_out_of_stock,
    output money_in, product_code, txn_valid, credit, coin_reject,
           refund_valid, refund, busy
  );

  modport master (
    output coin_valid, coin_value, sel_valid, sel_code, cancel,
           rsp_valid, rsp_dispense, rsp_change, rsp_out_of_stock,
    input  money_in, product_code, txn_valid, credit, coin_reject,
           refund_valid, refund, busy
  );
endinterface

// File: rtl/coin_credit_collector.sv
// Vending front-end: accumulates coin credit, issues one transaction to the
// vend stage, then returns change or refunds on cancel/timeout.
module coin_credit_collector #(
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned MAX_CREDIT  = 15,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned TO_W        = 10
) (
  input  logic         clk,
  input  logic         reset,
  coin_credit_if.slave bus_io
);

  localparam int unsigned SumW = CREDIT_W + 1;
  localparam logic [TO_W-1:0] TimerLast = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [SumW-1:0] MaxSum = SumW'(MAX_CREDIT);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StRequest,
    StWaitRsp,
    StRefund
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] money_in_q, money_in_d;
  logic [CREDIT_W-1:0] refund_q, refund_d;
  logic [2:0]          product_code_q, product_code_d;
  logic                txn_valid_q, txn_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                refund_valid_q, refund_valid_d;
  logic [TO_W-1:0]     timer_q, timer_d;

  logic [SumW-1:0]     coin_amt;
  logic [SumW-1:0]     coin_sum;
  logic                coin_fits;
  logic                coin_accept;
  logic [CREDIT_W-1:0] credit_post;
  logic                timeout;

  // Out-of-stock is informational only; the dispense flag drives all decisions.
  logic unused_oos;
  assign unused_oos = bus_io.rsp_out_of_stock;

  // Decode the coin code to its value.
  always_comb begin
    case (bus_io.coin_value)
      2'b00:   coin_amt = SumW'(1);
      2'b01:   coin_amt = SumW'(2);
      2'b10:   coin_amt = SumW'(5);
      default: coin_amt = SumW'(10);
    endcase
  end

  // One extra bit on the sum so an overflowing coin cannot wrap into range.
  assign coin_sum    = {1'b0, credit_q} + coin_amt;
  assign coin_fits   = (coin_sum <= MaxSum);
  assign coin_accept = bus_io.coin_valid && coin_fits;
  assign credit_post = coin_accept ? coin_sum[CREDIT_W-1:0] : credit_q;
  assign timeout     = (timer_q == TimerLast);

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    money_in_d     = money_in_q;
    product_code_d = product_code_q;
    txn_valid_d    = 1'b0;
    coin_reject_d  = 1'b0;
    refund_valid_d = 1'b0;
    refund_d       = '0;
    timer_d        = timer_q;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (bus_io.coin_valid) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = StCollect;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      StCollect: begin
        // The coin is resolved first so cancel/select see the updated credit.
        coin_reject_d = bus_io.coin_valid && !coin_fits;
        credit_d      = credit_post;
        timer_d       = coin_accept ? '0 : timer_q + TO_W'(1);
        if (bus_io.cancel) begin
          refund_valid_d = (credit_post != '0);
          refund_d       = credit_post;
          state_d        = StRefund;
        end else if (bus_io.sel_valid) begin
          product_code_d = bus_io.sel_code;
          money_in_d     = credit_post;
          txn_valid_d    = 1'b1;
          state_d        = StRequest;
        end else if (!coin_accept && timeout) begin
          refund_valid_d = (credit_post != '0);
          refund_d       = credit_post;
          state_d        = StRefund;
        end
      end

      StRequest: begin
        // Credit is committed to the vend stage; no more coins until it answers.
        coin_reject_d = bus_io.coin_valid;
        timer_d       = '0;
        state_d       = StWaitRsp;
      end

      StWaitRsp: begin
        coin_reject_d = bus_io.coin_valid;
        timer_d       = timer_q + TO_W'(1);
        if (bus_io.rsp_valid) begin
          timer_d = '0;
          if (bus_io.rsp_dispense) begin
            credit_d       = '0;
            money_in_d     = '0;
            refund_valid_d = (bus_io.rsp_change != '0);
            refund_d       = bus_io.rsp_change;
            state_d        = StIdle;
          end else begin
            state_d = StCollect;
          end
        end else if (timeout) begin
          refund_valid_d = (credit_q != '0);
          refund_d       = credit_q;
          state_d        = StRefund;
        end
      end

      StRefund: begin
        // The refund pulse is already on the outputs; settle back to empty.
        coin_reject_d = bus_io.coin_valid;
        credit_d      = '0;
        money_in_d    = '0;
        timer_d       = '0;
        state_d       = StIdle;
      end

      default: begin
        credit_d   = '0;
        money_in_d = '0;
        timer_d    = '0;
        state_d    = StIdle;
      end
    endcase
  end

  // State and output registers; reset discards any credit without refunding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      money_in_q     <= '0;
      product_code_q <= '0;
      txn_valid_q    <= 1'b0;
      coin_reject_q  <= 1'b0;
      refund_valid_q <= 1'b0;
      refund_q       <= '0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      money_in_q     <= money_in_d;
      product_code_q <= product_code_d;
      txn_valid_q    <= txn_valid_d;
      coin_reject_q  <= coin_reject_d;
      refund_valid_q <= refund_valid_d;
      refund_q       <= refund_d;
      timer_q        <= timer_d;
    end
  end

  assign bus_io.money_in     = money_in_q;
  assign bus_io.product_code = product_code_q;
  assign bus_io.txn_valid    = txn_valid_q;
  assign bus_io.credit       = credit_q;
  assign bus_io.coin_reject  = coin_reject_q;
  assign bus_io.refund_valid = refund_valid_q;
  assign bus_io.refund       = refund_q;
  assign bus_io.busy         = (state_q == StRequest) || (state_q == StWaitRsp) ||
                               (state_q == StRefund);

endmodule

// File: doc/coin_credit_collector.md
Name: coin_credit_collector

Overview:
Upstream front-end of the vending machine datapath. Accepts coin insertions and keypad selections, accumulates customer credit, and issues one registered transaction (money_in, product_code) to the vend stage. It then consumes the vend result and issues a refund/change pulse to the coin-return mechanism. It also handles cancel, credit overflow, and inactivity/response timeouts.

Parameters:
CREDIT_W, 4, width of credit, money_in, refund and rsp_change.
MAX_CREDIT, 15, maximum credit accepted; must be ≤ 2^CREDIT_W-1.
TIMEOUT_CYC, 1000, idle/response timeout in clk cycles.
TO_W, 10, timeout counter width; must satisfy 2^TO_W ≥ TIMEOUT_CYC.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
coin_valid  in  1  one-cycle coin-insert strobe.
coin_value  in  2  coin code: 00=1, 01=2, 10=5, 11=10.
sel_valid  in  1  one-cycle keypad selection strobe.
sel_code  in  3  selected product code.
cancel  in  1  one-cycle cancel strobe.
rsp_valid  in  1  vend result strobe.
rsp_dispense  in  1  vend stage dispensed.
rsp_change  in  CREDIT_W  change from vend stage.
rsp_out_of_stock  in  1  vend stage out-of-stock flag (status only).
money_in  out  CREDIT_W  credit offered to vend stage.
product_code  out  3  latched selection.
txn_valid  out  1  one-cycle transaction strobe.
credit  out  CREDIT_W  current accumulated credit.
coin_reject  out  1  one-cycle pulse; coin returned, not credited.
refund_valid  out  1  one-cycle pulse to coin return.
refund  out  CREDIT_W  amount to return, valid with refund_valid.
busy  out  1  high in REQUEST, WAIT_RSP and REFUND.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; timer 0. Reset mid-transaction discards credit; no refund pulse.
- All outputs are registered. Strobes are sampled on the rising edge; the response appears on the next cycle.
- Coin decode: 00→1, 01→2, 10→5, 11→10. Accept if credit+value ≤ MAX_CREDIT; otherwise credit is unchanged and coin_reject pulses. Compute the sum at CREDIT_W+1 bits so there is no wrap.
- IDLE (credit=0): an accepted coin moves to COLLECT. sel_valid and cancel are ignored.
- COLLECT: the timer increments every cycle and clears on each accepted coin.
- COLLECT priority: cancel > sel_valid > timeout. A coin in the same cycle is always evaluated first.
  - cancel → REFUND; the refund includes a same-cycle accepted coin.
  - sel_valid → latch sel_code, money_in=credit (including any same-cycle coin), → REQUEST.
  - timer == TIMEOUT_CYC-1 → REFUND.
- REQUEST: txn_valid=1 for exactly one cycle with money_in/product_code stable. Clear timer, → WAIT_RSP.
- WAIT_RSP: coins are rejected (coin_reject pulse). sel_valid and cancel are ignored. Timer runs.
  - rsp_valid && rsp_dispense → credit=0, money_in=0. If rsp_change ≠ 0: refund_valid=1, refund=rsp_change. → IDLE.
  - rsp_valid && !rsp_dispense (out of stock or insufficient) → credit retained, rsp_change ignored, timer cleared, → COLLECT.
  - No rsp_valid by timer == TIMEOUT_CYC-1 → REFUND of full credit.
- rsp_valid outside WAIT_RSP is ignored.
- REFUND: refund_valid=1 and refund=credit for one cycle (suppressed if credit=0). Then credit=0, money_in=0, → IDLE.
- money_in and product_code hold their last values until the next REQUEST or clear. The vend stage acts only on txn_valid.
- busy is derived from the registered state.

Test Plan:
1. Coins 5 then 10, sel_code=2 → credit=15; txn_valid one cycle with money_in=15, product_code=2. Then rsp_dispense=1, rsp_change=5 → refund_valid pulse, refund=5; credit=0; state IDLE.
2. Coins 10 then 10 → second coin gives coin_reject pulse, credit stays 10. Then coin 5 → credit=15.
3. Coin 5, sel_code=1, rsp_dispense=0, rsp_out_of_stock=1 → back to COLLECT with credit=5, no refund. Then cancel → refund=5, credit=0.
4. Coin 2, then no activity for TIMEOUT_CYC cycles → refund_valid with refund=2 exactly TIMEOUT_CYC cycles after the coin. With no response in WAIT_RSP → full-credit refund after TIMEOUT_CYC cycles.
5. In WAIT_RSP: coin_valid, cancel and sel_valid asserted → coin_reject pulse only; credit and state unchanged. Coin+cancel same cycle in COLLECT (credit 5, coin 2) → refund=7.
6. Assert reset during WAIT_RSP with credit=10 → immediately all outputs 0 and state IDLE; no refund_valid pulse. A later rsp_valid is ignored.
